// File: rtl/mux_pkg.sv
// Shared constants for the 4:1 round-robin stream mux and its arbiter.
package mux_pkg;
  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int NCH  = 4;
  localparam int CH_W = 2;

  function automatic logic [NCH-1:0] ch_onehot(input logic [CH_W-1:0] idx);
    return NCH'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_arb4.sv
// Combinational round-robin pick: first requester after last_grant, wrapping 3->0.
module rr_arb4
  import mux_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] last_grant,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_any
);

  logic [CH_W-1:0] c;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    c       = '0;
    for (int k = NCH; k >= 1; k--) begin
      c = last_grant + CH_W'(k);
      if (req[c]) begin
        gnt_idx = c;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4to1_rr_stream.sv
// Four valid/ready sources merged onto one registered output, round-robin
// arbitration with optional hold-until-last packet locking.
module mux4to1_rr_stream
  import mux_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter bit LOCK_PKT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        in_valid,
  input  logic [NCH*DATA_W-1:0] in_data,
  input  logic [NCH-1:0]        in_last,
  output logic [NCH-1:0]        in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic [CH_W-1:0]       out_sel,
  input  logic                  out_ready
);

  logic [0:0]      state;
  logic [CH_W-1:0] last_grant, lock_ch;
  logic [CH_W-1:0] arb_idx, gnt;
  logic            arb_any, gnt_any;
  logic            can_load, accept;

  rr_arb4 u_arb (
    .req        (in_valid),
    .last_grant (last_grant),
    .gnt_idx    (arb_idx),
    .gnt_any    (arb_any)
  );

  // While locked only the owning channel may move, valid or not.
  always_comb begin
    gnt     = arb_idx;
    gnt_any = arb_any;
    if (state == ST_LOCKED) begin
      gnt     = lock_ch;
      gnt_any = in_valid[lock_ch];
    end
  end

  assign can_load = !out_valid || out_ready;
  // rst_n gating keeps in_ready low for the whole reset pulse, not just after the edge.
  assign in_ready = (rst_n && can_load && gnt_any) ? ch_onehot(gnt) : '0;
  assign accept   = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ARB;
      last_grant <= CH_W'(NCH-1);
      lock_ch    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_sel    <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_data   <= in_data[gnt*DATA_W +: DATA_W];
      out_last   <= in_last[gnt];
      out_sel    <= gnt;
      last_grant <= gnt;
      if (LOCK_PKT && !in_last[gnt]) begin
        state   <= ST_LOCKED;
        lock_ch <= gnt;
      end else begin
        state <= ST_ARB;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4to1_rr_stream.sv
// Drives an unlocked (inst 0) and a packet-locked (inst 1) mux with the same
// stimulus and compares both against a per-cycle reference of the merge rules.
module tb_mux4to1_rr_stream;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic        out_ready;

  logic [3:0]  rdy  [2];
  logic        ov_d [2];
  logic [7:0]  od_d [2];
  logic        ol_d [2];
  logic [1:0]  os_d [2];

  int errors = 0;
  int checks = 0;

  // reference state
  int         m_lg  [2];
  bit         m_lk  [2];
  int         m_lch [2];
  bit         m_ov  [2];
  logic [7:0] m_od  [2];
  bit         m_ol  [2];
  int         m_os  [2];
  logic [3:0] last_rdy [2];

  always #5 clk = ~clk;

  mux4to1_rr_stream #(.DATA_W(8), .LOCK_PKT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy[0]), .out_valid(ov_d[0]),
    .out_data(od_d[0]), .out_last(ol_d[0]), .out_sel(os_d[0]),
    .out_ready(out_ready));

  mux4to1_rr_stream #(.DATA_W(8), .LOCK_PKT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy[1]), .out_valid(ov_d[1]),
    .out_data(od_d[1]), .out_last(ol_d[1]), .out_sel(os_d[1]),
    .out_ready(out_ready));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int m);
    if (m_lk[m]) return in_valid[m_lch[m]] ? m_lch[m] : -1;
    for (int k = 1; k <= 4; k++)
      if (in_valid[(m_lg[m] + k) % 4]) return (m_lg[m] + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_lg[m] = 3; m_lk[m] = 0; m_lch[m] = 0;
      m_ov[m] = 0; m_od[m] = 8'h00; m_ol[m] = 0; m_os[m] = 0;
    end
  endtask

  task automatic check_outs(input string pfx);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_valid%0d", pfx, m), 32'(ov_d[m]), 32'(m_ov[m]));
      chk($sformatf("%s_data%0d", pfx, m), 32'(od_d[m]), 32'(m_od[m]));
      chk($sformatf("%s_last%0d", pfx, m), 32'(ol_d[m]), 32'(m_ol[m]));
      chk($sformatf("%s_sel%0d", pfx, m), 32'(os_d[m]), 32'(m_os[m]));
    end
  endtask

  // One cycle: apply inputs, check ready and held outputs, clock, advance the reference.
  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                      input logic r);
    int  g [2];
    bit  acc [2];
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    #1;
    check_outs("hold");
    for (int m = 0; m < 2; m++) begin
      logic [3:0] er;
      g[m]   = pick(m);
      acc[m] = (g[m] >= 0) && (!m_ov[m] || r);
      er     = acc[m] ? 4'(1 << g[m]) : 4'b0;
      last_rdy[m] = rdy[m];
      chk($sformatf("in_ready%0d", m), 32'(rdy[m]), 32'(er));
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (acc[m]) begin
        m_ov[m] = 1; m_od[m] = d[g[m]*8 +: 8]; m_ol[m] = l[g[m]];
        m_os[m] = g[m]; m_lg[m] = g[m];
        m_lk[m] = (m == 1) && !l[g[m]];
        m_lch[m] = g[m];
      end else if (r) begin
        m_ov[m] = 0;
      end
    end
    @(negedge clk);
    check_outs("load");
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 4'hF; in_data = 32'h0; in_last = 4'h0; out_ready = 1'b1;
    model_reset();
    #1;
    chk("rst_ready0", 32'(rdy[0]), 32'h0);
    chk("rst_ready1", 32'(rdy[1]), 32'h0);
    repeat (2) @(negedge clk);
    check_outs("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // single beat on ch2
    step(4'b0100, 32'h00A5_0000, 4'b0100, 1'b1);
    chk("single_ready", 32'(last_rdy[1]), 32'h4);
    chk("single_valid", 32'(ov_d[1]), 32'h1);
    chk("single_data",  32'(od_d[1]), 32'hA5);
    chk("single_sel",   32'(os_d[1]), 32'h2);
    chk("single_last",  32'(ol_d[1]), 32'h1);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);
    chk("single_drain", 32'(ov_d[1]), 32'h0);

    // round-robin fairness from reset
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(4'hF, 32'h3322_1100 + 32'(k) * 32'h0101_0101, 4'hF, 1'b1);
      chk($sformatf("rr_sel%0d", k), 32'(os_d[1]), 32'(k % 4));
      chk($sformatf("rr_valid%0d", k), 32'(ov_d[1]), 32'h1);
    end

    // packet lock: ch1 sends 11,12,13 while ch0 and ch3 stay valid
    do_reset();
    step(4'b0001, 32'h0000_0001, 4'b0001, 1'b1);
    begin
      logic [7:0] beat [3];
      logic [7:0] exp_d [5];
      int         exp_s [5];
      beat[0] = 8'h11; beat[1] = 8'h12; beat[2] = 8'h13;
      exp_s[0] = 1; exp_s[1] = 1; exp_s[2] = 1; exp_s[3] = 3; exp_s[4] = 0;
      exp_d[0] = 8'h11; exp_d[1] = 8'h12; exp_d[2] = 8'h13; exp_d[3] = 8'h30; exp_d[4] = 8'h00;
      for (int k = 0; k < 5; k++) begin
        if (k < 3) step(4'b1011, {8'h30, 8'h00, beat[k], 8'h00}, {1'b1, 1'b0, (k == 2), 1'b1}, 1'b1);
        else       step(4'b1001, 32'h3000_0000, 4'b1001, 1'b1);
        chk($sformatf("lock_sel%0d", k), 32'(os_d[1]), 32'(exp_s[k]));
        chk($sformatf("lock_data%0d", k), 32'(od_d[1]), 32'(exp_d[k]));
      end
    end

    // backpressure: 3C held for 5 stalled cycles
    do_reset();
    step(4'b0001, 32'h0000_003C, 4'b0001, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(4'b0001, 32'h0000_0044, 4'b0001, 1'b0);
      chk($sformatf("bp_ready%0d", k), 32'(last_rdy[1]), 32'h0);
      chk($sformatf("bp_data%0d", k), 32'(od_d[1]), 32'h3C);
    end
    step(4'b0001, 32'h0000_0044, 4'b0001, 1'b1);
    chk("bp_next", 32'(od_d[1]), 32'h44);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);
    chk("bp_drain", 32'(ov_d[1]), 32'h0);

    // mid-packet stall: ch0 drops valid after beat 1, ch2 waiting
    do_reset();
    step(4'b0001, 32'h0000_00A1, 4'b0000, 1'b1);
    step(4'b0100, 32'h00C0_0000, 4'b0100, 1'b1);
    chk("stall_lock_ready", 32'(last_rdy[1]), 32'h0);
    chk("stall_free_ready", 32'(last_rdy[0]), 32'h4);
    step(4'b0100, 32'h00C1_0000, 4'b0100, 1'b1);
    chk("stall_lock_ready2", 32'(last_rdy[1]), 32'h0);
    step(4'b0101, 32'h00C2_00A2, 4'b0100, 1'b1);
    chk("stall_resume", 32'(last_rdy[1]), 32'h1);
    step(4'b0101, 32'h00C2_00A3, 4'b0101, 1'b1);
    chk("stall_last", 32'(od_d[1]), 32'hA3);
    step(4'b0100, 32'h00C2_0000, 4'b0100, 1'b1);
    chk("stall_ch2", 32'(last_rdy[1]), 32'h4);

    // async reset between edges, mid-packet on ch1
    step(4'b0010, 32'h0000_5500, 4'b0000, 1'b0);
    step(4'b0010, 32'h0000_5600, 4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_valid0", 32'(ov_d[0]), 32'h0);
    chk("arst_valid1", 32'(ov_d[1]), 32'h0);
    chk("arst_ready0", 32'(rdy[0]), 32'h0);
    chk("arst_ready1", 32'(rdy[1]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1010, 32'h7700_6600, 4'b1010, 1'b1);
    chk("arst_first", 32'(last_rdy[1]), 32'h2);

    // random traffic
    for (int k = 0; k < 400; k++)
      step(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
